// File: rtl/dpram_port_arbiter_pkg.sv
// Shared definitions for the dual-port RAM arbiter: default widths, RAM depth
// and the read-return tag carried from grant to rvalid.
package dpram_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;
  localparam int RAM_DEPTH = 1 << AW_DEF;
  // Wide enough for the largest supported requester count (8).
  localparam int TAG_IW = 3;

  typedef struct packed {
    logic              valid;
    logic [TAG_IW-1:0] idx;
  } tag_t;
endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Client-side request/response bus of the dual-port RAM arbiter (flattened lanes).
interface dpram_port_arbiter_if #(
  parameter int N  = 4,
  parameter int AW = 8,
  parameter int DW = 16
);
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [N*DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dpram_port_arbiter_rr_pick2.sv
// Rotating scan from ptr: returns the first two requesters found, wrapping mod N.
module dpram_port_arbiter_rr_pick2 #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found_a,
  output logic [IW-1:0] idx_a,
  output logic          found_b,
  output logic [IW-1:0] idx_b
);
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = IW'(j);
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = IW'(j);
        end
      end
    end
  end
endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the A/B
// ports of a dual-port RAM, with same-address hazard suppression and read return.
module dpram_port_arbiter
  import dpram_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  dpram_port_arbiter_if.slave bus,
  output logic          ram_ena,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dia,
  input  logic [DW-1:0] ram_doa,
  output logic          ram_enb,
  output logic          ram_web,
  output logic [AW-1:0] ram_addrb,
  output logic [DW-1:0] ram_dib,
  input  logic [DW-1:0] ram_dob
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr, idx_a, idx_b;
  logic          found_a, found_b, hazard, gnt_a, gnt_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          we_a, we_b;
  tag_t          tag_a, tag_b;
  logic [N-1:0]    gnt_v, rvalid_v;
  logic [N*DW-1:0] rdata_v;

  dpram_port_arbiter_rr_pick2 #(.N(N), .IW(IW)) u_pick (
    .req(bus.req), .ptr(ptr),
    .found_a(found_a), .idx_a(idx_a),
    .found_b(found_b), .idx_b(idx_b)
  );

  assign addr_a  = bus.addr[idx_a*AW +: AW];
  assign addr_b  = bus.addr[idx_b*AW +: AW];
  assign wdata_a = bus.wdata[idx_a*DW +: DW];
  assign wdata_b = bus.wdata[idx_b*DW +: DW];
  assign we_a    = bus.we[idx_a];
  assign we_b    = bus.we[idx_b];

  // Two reads of one address are safe; anything involving a write is not.
  assign hazard = (addr_a == addr_b) && (we_a || we_b);
  assign gnt_a  = found_a && !rst;
  assign gnt_b  = found_b && !hazard && !rst;

  always_comb begin
    gnt_v = '0;
    if (gnt_a) gnt_v[idx_a] = 1'b1;
    if (gnt_b) gnt_v[idx_b] = 1'b1;
  end
  assign bus.gnt = gnt_v;

  assign ram_ena   = gnt_a;
  assign ram_wea   = gnt_a && we_a;
  assign ram_addra = gnt_a ? addr_a : '0;
  assign ram_dia   = gnt_a ? wdata_a : '0;
  assign ram_enb   = gnt_b;
  assign ram_web   = gnt_b && we_b;
  assign ram_addrb = gnt_b ? addr_b : '0;
  assign ram_dib   = gnt_b ? wdata_b : '0;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(N-1)) ? '0 : i + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      tag_a <= '0;
      tag_b <= '0;
    end else begin
      if (gnt_b)      ptr <= nxt(idx_b);
      else if (gnt_a) ptr <= nxt(idx_a);
      tag_a <= '{valid: gnt_a && !we_a, idx: TAG_IW'(idx_a)};
      tag_b <= '{valid: gnt_b && !we_b, idx: TAG_IW'(idx_b)};
    end
  end

  // Masking with rst cancels a read return landing in the reset cycle.
  always_comb begin
    rvalid_v = '0;
    rdata_v  = '0;
    for (int i = 0; i < N; i++) begin
      if (!rst && tag_a.valid && tag_a.idx == TAG_IW'(i)) begin
        rvalid_v[i]          = 1'b1;
        rdata_v[i*DW +: DW]  = ram_doa;
      end
      if (!rst && tag_b.valid && tag_b.idx == TAG_IW'(i)) begin
        rvalid_v[i]          = 1'b1;
        rdata_v[i*DW +: DW]  = ram_dob;
      end
    end
  end
  assign bus.rvalid = rvalid_v;
  assign bus.rdata  = rdata_v;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench: arbiter plus a behavioural 256x16 dual-port RAM with 1-cycle read.
module tb_dpram_port_arbiter;
  localparam int N = 4, AW = 8, DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dpram_port_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  logic          ram_ena, ram_wea, ram_enb, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dia, ram_dib, ram_doa, ram_dob;

  dpram_port_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia), .ram_doa(ram_doa),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dib(ram_dib), .ram_dob(ram_dob)
  );

  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wea) mem[ram_addra] <= ram_dia;
      else         ram_doa <= mem[ram_addra];
    end
    if (ram_enb) begin
      if (ram_web) mem[ram_addrb] <= ram_dib;
      else         ram_dob <= mem[ram_addrb];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd(input int i, input logic [AW-1:0] a);
    bus.req[i] = 1'b1; bus.we[i] = 1'b0; bus.addr[i*AW +: AW] = a;
  endtask

  task automatic wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i] = 1'b1; bus.we[i] = 1'b1; bus.addr[i*AW +: AW] = a; bus.wdata[i*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rdat(input int i);
    return bus.rdata[i*DW +: DW];
  endfunction

  initial begin
    logic [N-1:0] exp_g, prev_g;
    int cnt [N];
    rst = 1'b1;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;

    // reset then idle
    tick(); tick(); #2;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_en", {ram_ena, ram_enb}, 0);
    tick(); rst = 1'b0; #2;
    chk("idle_gnt", 32'(bus.gnt), 0);
    chk("idle_rvalid", 32'(bus.rvalid), 0);
    chk("idle_rdata", bus.rdata[31:0], 0);
    chk("idle_rdata_hi", bus.rdata[63:32], 0);
    chk("idle_en", {ram_ena, ram_enb}, 0);

    // single write then read, only requester 0
    wr(0, 8'h10, 16'hBEEF); #2;
    chk("wr0_gnt", 32'(bus.gnt), 4'b0001);
    chk("wr0_porta", {ram_ena, ram_wea, ram_enb, ram_addra}, {3'b110, 8'h10});
    tick(); rd(0, 8'h10); #2;
    chk("rd0_gnt", 32'(bus.gnt), 4'b0001);
    chk("rd0_porta", {ram_ena, ram_wea, ram_enb}, 3'b100);
    tick(); bus.req = '0;
    wr(1, 8'h20, 16'h1234); wr(2, 8'h21, 16'h5678); #2;
    chk("rd0_rvalid", 32'(bus.rvalid), 4'b0001);
    chk("rd0_rdata", rdat(0), 16'hBEEF);
    chk("dualwr_gnt", 32'(bus.gnt), 4'b0110);
    chk("dualwr_we", {ram_wea, ram_web}, 2'b11);
    tick(); bus.req = '0;
    rd(3, 8'h00); #2;
    chk("wr_no_rvalid", 32'(bus.rvalid), 0);
    chk("r3_gnt", 32'(bus.gnt), 4'b1000);

    // dual read grant from ptr=0
    tick(); bus.req = '0;
    rd(1, 8'h20); rd(2, 8'h21); #2;
    chk("r3_rvalid", 32'(bus.rvalid), 4'b1000);
    chk("dual_gnt", 32'(bus.gnt), 4'b0110);
    chk("dual_addr", {ram_addra, ram_addrb}, 16'h2021);

    // hazard: write 0x40 on A blocks read 0x40 on B
    tick(); bus.req = '0;
    wr(0, 8'h40, 16'hA5A5); rd(1, 8'h40); #2;
    chk("dual_rvalid", 32'(bus.rvalid), 4'b0110);
    chk("dual_rdata1", rdat(1), 16'h1234);
    chk("dual_rdata2", rdat(2), 16'h5678);
    chk("haz_gnt1", 32'(bus.gnt), 4'b0001);
    chk("haz_enb", 32'(ram_enb), 0);
    tick(); bus.req[0] = 1'b0; #2;
    chk("haz_gnt2", 32'(bus.gnt), 4'b0010);
    chk("haz_addra", 32'(ram_addra), 8'h40);
    tick(); bus.req = '0;
    rd(2, 8'h10); rd(3, 8'h10); #2;
    chk("haz_rvalid", 32'(bus.rvalid), 4'b0010);
    chk("haz_rdata", rdat(1), 16'hA5A5);
    chk("same_rd_gnt", 32'(bus.gnt), 4'b1100);

    // fairness: all four read continuously
    tick();
    rd(0, 8'h10); rd(1, 8'h20); rd(2, 8'h21); rd(3, 8'h40);
    prev_g = 4'b1100;
    foreach (cnt[i]) cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      #2;
      exp_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      chk($sformatf("fair_gnt%0d", c), 32'(bus.gnt), 32'(exp_g));
      chk($sformatf("fair_rvalid%0d", c), 32'(bus.rvalid), 32'(prev_g));
      if (c == 0) chk("same_rd_data", {rdat(2), rdat(3)}, {16'hBEEF, 16'hBEEF});
      for (int i = 0; i < N; i++) if (bus.gnt[i]) cnt[i]++;
      prev_g = exp_g;
      tick();
    end
    for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), cnt[i], 4);

    // reset cancels a pending read return
    bus.req = '0; rd(1, 8'h21); #2;
    chk("fair_last_rvalid", 32'(bus.rvalid), 4'b1100);
    chk("pre_rst_gnt", 32'(bus.gnt), 4'b0010);
    tick(); bus.req = '0; rst = 1'b1; #2;
    chk("rst_cancel_rvalid", 32'(bus.rvalid), 0);
    chk("rst_gnt_mid", 32'(bus.gnt), 0);
    tick(); rst = 1'b0;
    rd(0, 8'h20); rd(2, 8'h21); #2;
    chk("post_rst_rvalid", 32'(bus.rvalid), 0);
    chk("post_rst_gnt", 32'(bus.gnt), 4'b0101);
    chk("post_rst_addra", 32'(ram_addra), 8'h20);
    tick(); bus.req = '0; #2;
    chk("post_rst_rv", 32'(bus.rvalid), 4'b0101);
    chk("post_rst_rd", {rdat(0), rdat(2)}, {16'h1234, 16'h5678});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
